tlb_mmu: RTL
============

# tlb_mmu

Parametrised MIPS32 memory-management unit replacing fixed segment mapping with a software-managed joint TLB. Translates one instruction and one data virtual address per cycle; results are registered. Also executes TLBWI/TLBR/TLBP requests from CP0. Sits between the pipeline's fetch/memory stages and the cache/bus interfaces.

## Interface
- `TLB_ENTRIES`, default 16, meaning number of entry pairs (2..64)
- `ASID_W`, default 8, meaning ASID width
- `clk` in 1: clock
- `rst_n` in 1: synchronous, active-low reset
- `asid` in `ASID_W`: current ASID (EntryHi.ASID)
- `kseg0_uncached` in 1: Config.K0 == 2
- `instr_req` in 1: translate `instr_v_addr` this cycle
- `instr_v_addr` in 32: fetch VA
- `instr_p_addr` out 32: registered PA
- `instr_uncached` out 1: registered uncached flag
- `instr_exc` out 2: 0 none, 1 refill, 2 invalid
- `data_req` in 1: translate `data_v_addr` this cycle
- `data_v_addr` in 32: load/store VA
- `data_we` in 1: access is a store
- `data_p_addr` out 32: registered PA
- `data_uncached` out 1: registered uncached flag
- `data_exc` out 2: 0 none, 1 refill, 2 invalid, 3 modified
- `op_valid` in 1: CP0 TLB op request
- `op_ready` out 1: accepting ops
- `op_code` in 2: 1 TLBWI, 2 TLBR, 3 TLBP
- `op_index` in `$clog2(TLB_ENTRIES)`: Index register
- `op_hi_in`, `op_lo0_in`, `op_lo1_in` in 32 each: EntryHi/EntryLo0/EntryLo1 for TLBWI and TLBP
- `op_done` out 1: one-cycle completion pulse
- `op_hi_out`, `op_lo0_out`, `op_lo1_out` out 32 each: TLBR result
- `probe_hit` out 1: TLBP matched
- `probe_index` out `$clog2(TLB_ENTRIES)`: TLBP index

## Operation
- Segments: kseg0 (`100`) → PA = VA & `0x1FFF_FFFF`, uncached = `kseg0_uncached`. kseg1 (`101`) → same PA, uncached = 1. kuseg and kseg2/3 are mapped.
- Entry: VPN2[31:13], ASID, G, and per-page PFN[25:6], C[5:3], D, V (EntryLo format). 4 KB pages only. `op_hi_in`[12:8] and the PageMask register are ignored.
- Match: VPN2 equal and (G or ASID equal). VA[12] selects lo0/lo1. PA = {PFN[19:0], VA[11:0]}. Mapped uncached when C == 2.
- Exceptions are evaluated in this priority: no match → refill; V = 0 → invalid; `data_we` and D = 0 → modified (data only). When an exception is reported, the PA is 0.
- Multiple matches: the lowest index wins. No error is flagged.
- TLBWI: writes entry `op_index`. Lo G bits are ANDed into the stored G.
- TLBR: returns entry `op_index`. The G bit is replicated into lo0/lo1 bit 0.
- TLBP: matches `op_hi_in` VPN2/ASID and reports `probe_hit`/`probe_index`.
- `op_index` ≥ `TLB_ENTRIES`: the write is ignored and the read returns all zeros.

## Timing
- Translation latency is 1 cycle. Results are registered on the edge where `*_req` = 1.
- With `*_req` = 0, the channel's outputs hold their previous values.
- Op FSM has two states:
  - IDLE (`op_ready` = 1). On `op_valid`, capture the op and move to BUSY.
  - BUSY (`op_ready` = 0). Perform the op, pulse `op_done` on the following cycle with results valid, then return to IDLE.
- Throughput: one op per 2 cycles.
- A TLBWI commits at the end of BUSY. Lookups in that same cycle see the old contents; the new entry is visible from the next cycle.
- TLBP and TLBR results hold until the next op.
- Reset: all entries are zeroed (V = 0, G = 0). All outputs are 0 except `op_ready` = 1. The FSM returns to IDLE. An op in flight at reset is dropped and gets no `op_done`.

## Configuration
- `MMU_TLB_EN` defined: full TLB behaviour as above.
- `MMU_TLB_EN` undefined:
  - No TLB storage.
  - Mapped segments pass through with identity PA, cached, and `*_exc` = 0.
  - Ops still handshake and pulse `op_done`, but return all-zero data with `probe_hit` = 0.

## Structure
- `mmu_pkg` contains:
  - `tlb_entry_t` struct
  - `tlb_op_e` enum
  - `mmu_exc_e` enum
  - segment constants `SEG_KSEG0 = 3'b100` and `SEG_KSEG1 = 3'b101`
  - `UNCACHED_C = 3'd2`
- Sub-module `tlb_match`: combinational match plus priority encoder over the entry array. It has three instances: instruction, data, and probe.

## Test plan
- After reset, `instr_v_addr = 0x8000_1000` → `instr_p_addr = 0x0000_1000`, uncached = 0. With `kseg0_uncached` = 1, uncached = 1.
- Empty TLB, `data_v_addr = 0x0040_0000` → `data_exc` = 1 (refill).
- TLBWI index 3 with hi = `0x0040_0000`/ASID 5, lo0 PFN = `0x12`, V = 1, D = 0, C = 3:
  - Load from `0x0040_0ABC`, `asid` = 5 → `data_p_addr` = `0x0001_2ABC`, uncached = 0.
  - Store to the same address → exc = 3 (modified).
  - Load with `asid` = 6 → exc = 1 (refill).
- TLBP with hi = `0x0040_0005` → `probe_hit` = 1, `probe_index` = 3. TLBR index 3 returns the written values.
- Entries 2 and 7 both match `0xC000_0000`, G = 1 → PA taken from entry 2. `op_valid` held high for back-to-back ops → `op_done` every second cycle.
- `rst_n` low while in BUSY → no `op_done`. A lookup of the previously written VA then returns refill.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types and constants for the tlb_mmu slice.
package mmu_pkg;

    localparam logic [2:0] SEG_KSEG0  = 3'b100;
    localparam logic [2:0] SEG_KSEG1  = 3'b101;
    localparam logic [2:0] UNCACHED_C = 3'd2;

    typedef enum logic [1:0] {
        OpNone  = 2'd0,
        OpTlbwi = 2'd1,
        OpTlbr  = 2'd2,
        OpTlbp  = 2'd3
    } tlb_op_e;

    typedef enum logic [1:0] {
        ExcNone     = 2'd0,
        ExcRefill   = 2'd1,
        ExcInvalid  = 2'd2,
        ExcModified = 2'd3
    } mmu_exc_e;

    // One 4 KB page of an entry pair, EntryLo fields without G
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_lo_t;

    // ASID lives beside the entry because its width is a module parameter
    typedef struct packed {
        logic [18:0] vpn2;
        logic        g;
        tlb_lo_t     lo0;
        tlb_lo_t     lo1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] pa;
        logic        unc;
        mmu_exc_e    exc;
    } xlate_t;

    function automatic tlb_lo_t lo_unpack(input logic [25:1] lo);
        tlb_lo_t r;
        r.pfn = lo[25:6];
        r.c   = lo[5:3];
        r.d   = lo[2];
        r.v   = lo[1];
        return r;
    endfunction

    function automatic logic [31:0] lo_pack(input tlb_lo_t lo, input logic g);
        return {6'b0, lo.pfn, lo.c, lo.d, lo.v, g};
    endfunction

    // Segment decode plus page checks; lo is the already selected even/odd page
    function automatic xlate_t xlate(input logic [31:0] va, input logic we, input logic k0_unc,
                                     input logic mapped_en, input logic hit, input tlb_lo_t lo);
        xlate_t r;
        r.pa  = 32'h0;
        r.unc = 1'b0;
        r.exc = ExcNone;
        if (va[31:29] == SEG_KSEG0) begin
            r.pa  = va & 32'h1FFF_FFFF;
            r.unc = k0_unc;
        end else if (va[31:29] == SEG_KSEG1) begin
            r.pa  = va & 32'h1FFF_FFFF;
            r.unc = 1'b1;
        end else if (!mapped_en) begin
            r.pa = va;
        end else if (!hit) begin
            r.exc = ExcRefill;
        end else if (!lo.v) begin
            r.exc = ExcInvalid;
        end else if (we && !lo.d) begin
            r.exc = ExcModified;
        end else begin
            r.pa  = {lo.pfn, va[11:0]};
            r.unc = (lo.c == UNCACHED_C);
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational VPN2/ASID match over the entry array; lowest matching index wins.
module tlb_match
    import mmu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ASID_W  = 8,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  tlb_entry_t        entries    [ENTRIES],
    input  logic [ASID_W-1:0] entry_asid [ENTRIES],
    input  logic [18:0]       vpn2,
    input  logic [ASID_W-1:0] asid,
    output logic              hit,
    output logic [IDX_W-1:0]  index
);

    logic unused_lo;

    // Scan from the top down so the lowest index overwrites the others
    always_comb begin
        hit       = 1'b0;
        index     = '0;
        unused_lo = 1'b0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            unused_lo = unused_lo ^ (^{entries[i].lo0, entries[i].lo1});
            if (entries[i].vpn2 == vpn2 && (entries[i].g || entry_asid[i] == asid)) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_mmu.sv
// MIPS32 MMU with software-managed joint TLB, one instruction and one data
// translation per cycle plus TLBWI/TLBR/TLBP ops. Define MMU_TLB_EN for the
// TLB; without it mapped segments pass through and ops return zeros.
module tlb_mmu
    import mmu_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 16,
    parameter int unsigned ASID_W      = 8,
    localparam int unsigned IDX_W      = $clog2(TLB_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ASID_W-1:0] asid,
    input  logic              kseg0_uncached,
    input  logic              instr_req,
    input  logic [31:0]       instr_v_addr,
    output logic [31:0]       instr_p_addr,
    output logic              instr_uncached,
    output logic [1:0]        instr_exc,
    input  logic              data_req,
    input  logic [31:0]       data_v_addr,
    input  logic              data_we,
    output logic [31:0]       data_p_addr,
    output logic              data_uncached,
    output logic [1:0]        data_exc,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [IDX_W-1:0]  op_index,
    input  logic [31:0]       op_hi_in,
    input  logic [31:0]       op_lo0_in,
    input  logic [31:0]       op_lo1_in,
    output logic              op_done,
    output logic [31:0]       op_hi_out,
    output logic [31:0]       op_lo0_out,
    output logic [31:0]       op_lo1_out,
    output logic              probe_hit,
    output logic [IDX_W-1:0]  probe_index
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q;
    tlb_op_e          op_code_q;
    logic [IDX_W-1:0] op_index_q;
    logic [31:0]      op_hi_q, op_lo0_q, op_lo1_q;
    logic             idx_ok;
    logic             i_hit, d_hit;
    tlb_lo_t          i_lo, d_lo;
    xlate_t           ix, dx;
    logic             unused_in;

    assign op_ready  = (state_q == StIdle);
    assign unused_in = ^{asid, op_code_q, op_index_q, op_hi_q, op_lo0_q, op_lo1_q};

    // Out-of-range indices only exist when the entry count is not a power of two
    if (TLB_ENTRIES == (1 << IDX_W)) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_part
        assign idx_ok = (32'(op_index_q) < TLB_ENTRIES);
    end

`ifdef MMU_TLB_EN
    localparam bit TlbEn = 1'b1;

    tlb_entry_t        entries_q [TLB_ENTRIES];
    logic [ASID_W-1:0] asid_q    [TLB_ENTRIES];
    logic [IDX_W-1:0]  i_idx, d_idx, p_idx;
    logic              p_hit;
    tlb_entry_t        rd_entry;
    logic [ASID_W-1:0] rd_asid;

    tlb_match #(.ENTRIES(TLB_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) u_match_instr (
        .entries(entries_q), .entry_asid(asid_q), .vpn2(instr_v_addr[31:13]), .asid(asid),
        .hit(i_hit), .index(i_idx)
    );
    tlb_match #(.ENTRIES(TLB_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) u_match_data (
        .entries(entries_q), .entry_asid(asid_q), .vpn2(data_v_addr[31:13]), .asid(asid),
        .hit(d_hit), .index(d_idx)
    );
    tlb_match #(.ENTRIES(TLB_ENTRIES), .ASID_W(ASID_W), .IDX_W(IDX_W)) u_match_probe (
        .entries(entries_q), .entry_asid(asid_q), .vpn2(op_hi_q[31:13]),
        .asid(op_hi_q[ASID_W-1:0]), .hit(p_hit), .index(p_idx)
    );

    assign i_lo     = instr_v_addr[12] ? entries_q[i_idx].lo1 : entries_q[i_idx].lo0;
    assign d_lo     = data_v_addr[12] ? entries_q[d_idx].lo1 : entries_q[d_idx].lo0;
    assign rd_entry = entries_q[op_index_q];
    assign rd_asid  = asid_q[op_index_q];

    // Entry storage; TLBWI commits on the last edge of BUSY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
                entries_q[i] <= '0;
                asid_q[i]    <= '0;
            end
        end else if (state_q == StBusy && op_code_q == OpTlbwi && idx_ok) begin
            entries_q[op_index_q].vpn2 <= op_hi_q[31:13];
            entries_q[op_index_q].g    <= op_lo0_q[0] & op_lo1_q[0];
            entries_q[op_index_q].lo0  <= lo_unpack(op_lo0_q[25:1]);
            entries_q[op_index_q].lo1  <= lo_unpack(op_lo1_q[25:1]);
            asid_q[op_index_q]         <= op_hi_q[ASID_W-1:0];
        end
    end
`else
    localparam bit TlbEn = 1'b0;

    assign i_hit = 1'b0;
    assign d_hit = 1'b0;
    assign i_lo  = '0;
    assign d_lo  = '0;
`endif

    assign ix = xlate(instr_v_addr, 1'b0, kseg0_uncached, TlbEn, i_hit, i_lo);
    assign dx = xlate(data_v_addr, data_we, kseg0_uncached, TlbEn, d_hit, d_lo);

    // Instruction channel result register, held while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_p_addr   <= '0;
            instr_uncached <= 1'b0;
            instr_exc      <= '0;
        end else if (instr_req) begin
            instr_p_addr   <= ix.pa;
            instr_uncached <= ix.unc;
            instr_exc      <= ix.exc;
        end
    end

    // Data channel result register, held while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p_addr   <= '0;
            data_uncached <= 1'b0;
            data_exc      <= '0;
        end else if (data_req) begin
            data_p_addr   <= dx.pa;
            data_uncached <= dx.unc;
            data_exc      <= dx.exc;
        end
    end

    // Op FSM: capture in IDLE, execute in BUSY, pulse op_done with results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_code_q   <= OpNone;
            op_index_q  <= '0;
            op_hi_q     <= '0;
            op_lo0_q    <= '0;
            op_lo1_q    <= '0;
            op_done     <= 1'b0;
            op_hi_out   <= '0;
            op_lo0_out  <= '0;
            op_lo1_out  <= '0;
            probe_hit   <= 1'b0;
            probe_index <= '0;
        end else begin
            op_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (op_valid) begin
                        op_code_q  <= tlb_op_e'(op_code);
                        op_index_q <= op_index;
                        op_hi_q    <= op_hi_in;
                        op_lo0_q   <= op_lo0_in;
                        op_lo1_q   <= op_lo1_in;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    op_done     <= 1'b1;
                    state_q     <= StIdle;
                    op_hi_out   <= '0;
                    op_lo0_out  <= '0;
                    op_lo1_out  <= '0;
                    probe_hit   <= 1'b0;
                    probe_index <= '0;
`ifdef MMU_TLB_EN
                    if (op_code_q == OpTlbr && idx_ok) begin
                        op_hi_out  <= {rd_entry.vpn2, 13'(rd_asid)};
                        op_lo0_out <= lo_pack(rd_entry.lo0, rd_entry.g);
                        op_lo1_out <= lo_pack(rd_entry.lo1, rd_entry.g);
                    end
                    if (op_code_q == OpTlbp) begin
                        probe_hit   <= p_hit;
                        probe_index <= p_idx;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
